// File: rtl/score_pkg.sv
// Shared definitions for the score accumulator: opcodes, FSM states and
// the saturation limits of the 20-bit signed score.
package score_pkg;

    localparam int SCORE_W = 20;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 20'h7FFFF;
    localparam logic [SCORE_W-1:0] SCORE_MIN = 20'h80000;

endpackage

// File: rtl/score_adder.sv
// Shared two's-complement ripple adder used by the arcade datapath.
// Purely combinational; score_accumulator feeds it and consumes the sum.
module score_adder #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b + {{(WIDTH-1){1'b0}}, ci};

endmodule

// File: rtl/score_accumulator.sv
// Signed score accumulator: takes add/sub/clear/load commands over valid/ready,
// drives the external adder from registers only, saturates and holds the score.
module score_accumulator
    import score_pkg::*;
#(
    parameter int WIDTH = SCORE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_value,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] score,
    output logic             done,
    output logic             ovf
);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic signed [WIDTH-1:0] val_q, val_d;
    logic signed [WIDTH-1:0] score_q, score_d;
    logic                    ovf_q, ovf_d;

    function automatic logic add_overflow(input logic signed [WIDTH-1:0] a,
                                          input logic signed [WIDTH-1:0] b,
                                          input logic signed [WIDTH-1:0] sum);
        return (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Overflow always saturates toward the sign of the accumulated operand.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] a);
        return a[WIDTH-1] ? SCORE_MIN : SCORE_MAX;
    endfunction

    // Adder operands depend on registered state only, so they are stable
    // from the first moment of EXEC regardless of what upstream is driving.
    always_comb begin
        add_a  = score_q;
        add_b  = '0;
        add_ci = 1'b0;
        if (state_q == EXEC) begin
            if (op_q == OP_ADD) begin
                add_b = val_q;
            end else if (op_q == OP_SUB) begin
                add_b  = ~val_q;
                add_ci = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        val_d    = val_q;
        score_d  = score_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op_e'(in_op);
                    val_d   = in_value;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        if (add_overflow(add_a, add_b, add_sum)) begin
                            score_d = saturate(add_a);
                            ovf_d   = 1'b1;
                        end else begin
                            score_d = add_sum;
                        end
                    end
                    OP_CLEAR: begin
                        score_d = '0;
                        ovf_d   = 1'b0;
                    end
                    default: score_d = val_q;
                endcase
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            val_q   <= '0;
            score_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            val_q   <= val_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
        end
    end

    assign score = score_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Self-checking bench for score_accumulator wired to the real score_adder.
module tb_score_accumulator;
    import score_pkg::*;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_value;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_ci;
    logic [W-1:0] score;
    logic         done;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: true integer score clamped to the 20-bit signed range.
    int m_score = 0;
    bit m_ovf   = 1'b0;

    // Observations captured by do_cmd in the EXEC, DONE and following IDLE cycle.
    logic         ex_ready, ex_done, ex_ci;
    logic [W-1:0] ex_a, ex_b;
    logic         dn_ready, dn_done, dn_ovf;
    logic [W-1:0] dn_score;
    logic         af_ready, af_done;

    always #5 clk = ~clk;

    score_adder #(.WIDTH(W)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .ci  (add_ci),
        .sum (add_sum)
    );

    score_accumulator #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_value (in_value),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ci   (add_ci),
        .add_sum  (add_sum),
        .score    (score),
        .done     (done),
        .ovf      (ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_apply(input logic [1:0] op, input logic [W-1:0] v);
        int sv;
        int r;
        sv = int'($signed(v));
        case (op)
            2'b00: r = m_score + sv;
            2'b01: r = m_score - sv;
            2'b10: begin m_score = 0; m_ovf = 1'b0; return; end
            default: begin m_score = sv; return; end
        endcase
        if (r > 524287) begin
            r = 524287;
            m_ovf = 1'b1;
        end else if (r < -524288) begin
            r = -524288;
            m_ovf = 1'b1;
        end
        m_score = r;
    endfunction

    function automatic logic [W-1:0] model_bits();
        int tmp;
        tmp = m_score;
        return tmp[W-1:0];
    endfunction

    // Issue one command from an IDLE-aligned point (#1 after an edge).
    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] v);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_timeout: in_ready=%b required 1", in_ready);
            return;
        end
        model_apply(op, v);
        in_valid = 1'b1;
        in_op    = op;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom_range(3, 0));
        in_value = W'($urandom);
        ex_ready = in_ready; ex_done = done; ex_a = add_a; ex_b = add_b; ex_ci = add_ci;
        @(posedge clk); #1;
        dn_ready = in_ready; dn_done = done; dn_score = score; dn_ovf = ovf;
        @(posedge clk); #1;
        af_ready = in_ready; af_done = done;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_score = 0;
        m_ovf   = 1'b0;
        n_checks++; if (score !== 20'h00000) begin n_fail++; $display("FAIL reset_score: got %h want 00000", score); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++; if (add_b !== 20'h00000 || add_ci !== 1'b0 || add_a !== 20'h00000) begin
            n_fail++; $display("FAIL reset_adder: a=%h b=%h ci=%b want 00000/00000/0", add_a, add_b, add_ci);
        end
    endtask

    task automatic test_add();
        do_cmd(2'b00, 20'd100);
        n_checks++; if (ex_ready !== 1'b0 || ex_done !== 1'b0) begin n_fail++; $display("FAIL add_exec_ctl: ready=%b done=%b want 0/0", ex_ready, ex_done); end
        n_checks++; if (ex_a !== 20'h00000 || ex_b !== 20'd100 || ex_ci !== 1'b0) begin
            n_fail++; $display("FAIL add_exec_operands: a=%h b=%h ci=%b want 00000/00064/0", ex_a, ex_b, ex_ci);
        end
        n_checks++; if (dn_done !== 1'b1 || dn_ready !== 1'b0) begin n_fail++; $display("FAIL add_done_ctl: done=%b ready=%b want 1/0", dn_done, dn_ready); end
        n_checks++; if (af_ready !== 1'b1 || af_done !== 1'b0) begin n_fail++; $display("FAIL add_after_ctl: ready=%b done=%b want 1/0", af_ready, af_done); end
        n_checks++; if (dn_score !== 20'd100) begin n_fail++; $display("FAIL add_first: got %h want 00064", dn_score); end
        do_cmd(2'b00, 20'd23);
        n_checks++; if (dn_done !== 1'b1) begin n_fail++; $display("FAIL add2_done: got %b want 1", dn_done); end
        n_checks++; if (dn_score !== 20'd123 || dn_ovf !== 1'b0) begin
            n_fail++; $display("FAIL add2_score: got %h ovf=%b want 0007b ovf=0", dn_score, dn_ovf);
        end
    endtask

    task automatic test_sub();
        do_cmd(2'b11, 20'h00005);
        do_cmd(2'b01, 20'd8);
        n_checks++; if (ex_b !== 20'hFFFF7 || ex_ci !== 1'b1 || ex_a !== 20'h00005) begin
            n_fail++; $display("FAIL sub_operands: a=%h b=%h ci=%b want 00005/ffff7/1", ex_a, ex_b, ex_ci);
        end
        n_checks++; if (dn_score !== 20'hFFFFD || dn_ovf !== 1'b0) begin
            n_fail++; $display("FAIL sub_result: got %h ovf=%b want ffffd ovf=0", dn_score, dn_ovf);
        end
    endtask

    task automatic test_saturate();
        do_cmd(2'b11, 20'h7FFF0);
        do_cmd(2'b00, 20'h00020);
        n_checks++; if (dn_score !== 20'h7FFFF || dn_ovf !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos: got %h ovf=%b want 7ffff ovf=1", dn_score, dn_ovf);
        end
        do_cmd(2'b00, 20'hFFFFF);
        n_checks++; if (dn_score !== 20'h7FFFE || dn_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %h ovf=%b want 7fffe ovf=1", dn_score, dn_ovf);
        end
        do_cmd(2'b10, 20'h12345);
        n_checks++; if (dn_score !== 20'h00000 || dn_ovf !== 1'b0) begin
            n_fail++; $display("FAIL clear: got %h ovf=%b want 00000 ovf=0", dn_score, dn_ovf);
        end
    endtask

    task automatic test_sub_sat();
        do_cmd(2'b11, 20'h00000);
        do_cmd(2'b01, 20'h80000);
        n_checks++; if (dn_score !== 20'h7FFFF || dn_ovf !== 1'b1) begin
            n_fail++; $display("FAIL sub_min: got %h ovf=%b want 7ffff ovf=1", dn_score, dn_ovf);
        end
        do_cmd(2'b10, 20'h00000);
        do_cmd(2'b11, 20'h80000);
        do_cmd(2'b01, 20'h00001);
        n_checks++; if (dn_score !== 20'h80000 || dn_ovf !== 1'b1) begin
            n_fail++; $display("FAIL sat_neg: got %h ovf=%b want 80000 ovf=1", dn_score, dn_ovf);
        end
        // Exact limits are representable and must not flag overflow.
        do_cmd(2'b10, 20'h00000);
        do_cmd(2'b11, 20'h7FFFE);
        do_cmd(2'b00, 20'h00001);
        n_checks++; if (dn_score !== 20'h7FFFF || dn_ovf !== 1'b0) begin
            n_fail++; $display("FAIL exact_max: got %h ovf=%b want 7ffff ovf=0", dn_score, dn_ovf);
        end
        do_cmd(2'b11, 20'h80001);
        do_cmd(2'b01, 20'h00001);
        n_checks++; if (dn_score !== 20'h80000 || dn_ovf !== 1'b0) begin
            n_fail++; $display("FAIL exact_min: got %h ovf=%b want 80000 ovf=0", dn_score, dn_ovf);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int dones;
        int misplaced;
        accepts = 0; dones = 0; misplaced = 0;
        do_cmd(2'b10, 20'h00000);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_value = 20'h00001;
        for (int i = 0; i < 12; i++) begin
            if (in_ready === 1'b1) begin
                accepts++;
                model_apply(2'b00, 20'h00001);
            end
            if (done === 1'b1) begin
                dones++;
                if (i % 3 != 2) misplaced++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (accepts != 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", accepts); end
        n_checks++; if (dones != 4 || misplaced != 0) begin
            n_fail++; $display("FAIL b2b_done_pulses: got %0d (misplaced %0d) want 4 (misplaced 0)", dones, misplaced);
        end
        n_checks++; if (score !== 20'd4 || score !== model_bits()) begin
            n_fail++; $display("FAIL b2b_score: got %h want 00004", score);
        end
    endtask

    task automatic test_reset_mid();
        int late_done;
        late_done = 0;
        do_cmd(2'b11, 20'h7FFFF);
        do_cmd(2'b00, 20'h00001);
        do_cmd(2'b11, 20'd7);
        n_checks++; if (dn_score !== 20'd7 || dn_ovf !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: got %h ovf=%b want 00007 ovf=1", dn_score, dn_ovf);
        end
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_value = 20'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_score = 0;
        m_ovf   = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_checks++; if (score !== 20'h00000 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: got %h ovf=%b want 00000 ovf=0", score, ovf);
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) late_done++;
            @(posedge clk); #1;
        end
        n_checks++; if (late_done != 0 || score !== 20'h00000) begin
            n_fail++; $display("FAIL rstmid_aborted: done pulses=%0d score=%h want 0/00000", late_done, score);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] corners [6];
        logic [W-1:0] v;
        logic [W-1:0] prev;
        logic [W-1:0] want_b;
        logic         want_ci;
        logic [1:0]   op;
        corners[0] = 20'h00000; corners[1] = 20'h00001; corners[2] = 20'h7FFFF;
        corners[3] = 20'h80000; corners[4] = 20'hFFFFF; corners[5] = 20'h7FFFE;
        do_cmd(2'b10, 20'h00000);
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) v = corners[$urandom_range(5, 0)];
            else v = W'($urandom);
            prev    = model_bits();
            want_b  = (op == 2'b00) ? v : (op == 2'b01) ? ~v : '0;
            want_ci = (op == 2'b01);
            do_cmd(op, v);
            n_checks++; if (ex_a !== prev || ex_b !== want_b || ex_ci !== want_ci) begin
                n_fail++; $display("FAIL rand_operands[%0d]: a=%h b=%h ci=%b want %h/%h/%b", i, ex_a, ex_b, ex_ci, prev, want_b, want_ci);
            end
            n_checks++; if (dn_score !== model_bits() || dn_ovf !== m_ovf || dn_done !== 1'b1) begin
                n_fail++; $display("FAIL rand_result[%0d]: op=%0d v=%h got %h ovf=%b done=%b want %h ovf=%b done=1",
                                   i, op, v, dn_score, dn_ovf, dn_done, model_bits(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_saturate();
        test_sub_sat();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
